// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch unit signal bundle: imem request/response, redirect, if_id output
interface ifu_fetch_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    modport master (
        output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, jump_en_i, jump_addr_i, hold_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, jump_en_i, jump_addr_i, hold_i
    );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit with DEPTH-entry prefetch queue and jump redirect
// Optional same-cycle rdata-to-inst bypass enabled by defining IFU_BYPASS_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    ifu_fetch_if.master   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]       r_pc;
    logic [31:0]       r_addr [DEPTH];
    logic [31:0]       r_data [DEPTH];
    logic [DEPTH-1:0]  r_filled;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_fill_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_pend;
    logic [CW-1:0]     r_kill;

    logic [CW:0]       w_used;
    logic              w_req;
    logic              w_hs;
    logic              w_gnt;
    logic              w_live_rv;
    logic              w_kill_rv;
    logic              w_head_filled;
    logic              w_byp;
    logic              w_valid;
    logic              w_cons;
    logic              w_jump;
    logic              w_unused;

    // Killed responses still occupy credit so the memory never holds more than DEPTH.
    assign w_used        = {1'b0, r_count} + {1'b0, r_kill};
    assign w_req         = !rst && (w_used < (CW+1)'(DEPTH));
    assign w_jump        = bus.jump_en_i;
    assign w_hs          = w_req && bus.mem_gnt_i;
    assign w_gnt         = w_hs && !w_jump;
    assign w_kill_rv     = bus.mem_rvalid_i && (r_kill != '0);
    assign w_live_rv     = bus.mem_rvalid_i && (r_kill == '0);
    assign w_head_filled = r_filled[r_rd_ptr];
    assign w_unused      = ^bus.jump_addr_i[1:0];

`ifdef IFU_BYPASS_EN
    assign w_byp = w_live_rv && !w_head_filled && (r_pend != '0) && (r_fill_ptr == r_rd_ptr);
`else
    assign w_byp = 1'b0;
`endif

    assign w_valid = w_head_filled || w_byp;
    assign w_cons  = w_valid && !bus.hold_i && !w_jump;

    assign bus.mem_req_o    = w_req;
    assign bus.mem_addr_o   = r_pc;
    assign bus.inst_valid_o = w_valid;
    assign bus.inst_o       = w_head_filled ? r_data[r_rd_ptr] :
                              w_byp         ? bus.mem_rdata_i  : NOP;
    assign bus.inst_addr_o  = w_valid ? r_addr[r_rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (w_gnt) begin
            r_addr[r_wr_ptr] <= r_pc;
        end
        if (w_live_rv && !w_jump) begin
            r_data[r_fill_ptr] <= bus.mem_rdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_filled   <= '0;
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            r_kill     <= '0;
        end else if (w_jump) begin
            // Everything outstanding on the old path, including this cycle's grant, must be dropped.
            r_pc       <= {bus.jump_addr_i[31:2], 2'b00};
            r_filled   <= '0;
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            r_kill     <= r_pend + CW'(w_hs) - CW'(w_live_rv) + r_kill - CW'(w_kill_rv);
        end else begin
            if (w_gnt) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_kill_rv) begin
                r_kill <= r_kill - CW'(1);
            end
            if (w_live_rv) begin
                r_fill_ptr <= r_fill_ptr + PW'(1);
                if (!(w_byp && w_cons)) begin
                    r_filled[r_fill_ptr] <= 1'b1;
                end
            end
            if (w_cons) begin
                r_filled[r_rd_ptr] <= 1'b0;
                r_rd_ptr           <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_gnt) - CW'(w_cons);
            r_pend  <= r_pend + CW'(w_gnt) - CW'(w_live_rv);
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch: vector table, directed corners, random memory
module tb_ifu_fetch;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_fetch_if bus();
    ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        hold;
        logic        jump;
        logic [31:0] jaddr;
        logic        req;
        logic [31:0] maddr;
        logic        v_nb;
        logic        v_b;
        logic [31:0] ia;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } resp_t;

    vec_t  tbl [14];
    resp_t q[$];

    int n_vec = 0;
    int n_err = 0;

    int          cyc, last_due, cur_ep, n_live, n_ready;
    logic [31:0] exp_pc, exp_req_pc;
    int          p_gnt, p_hold, p_jump, lat_min, lat_max;
    bit          fj, fj_co, co_done, seen_valid, wrap_phase, saw_wrap;
    logic [31:0] fj_addr, first_va;
    int          n_cons;

    function automatic vec_t mk(bit g, bit rv, logic [31:0] d, bit h, bit j, logic [31:0] ja,
                                bit req, logic [31:0] ma, bit vnb, bit vb, logic [31:0] ia);
        mk = '{g, rv, d, h, j, ja, req, ma, vnb, vb, ia};
    endfunction

    function automatic logic [31:0] word(logic [31:0] a);
        word = a ^ 32'h3C3C_A5A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        bus.hold_i       = 1'b0;
        bus.jump_en_i    = 1'b0;
        bus.jump_addr_i  = 32'h0;
    endtask

    task automatic model_clear();
        q.delete();
        last_due   = 0;
        cur_ep     = 0;
        n_live     = 0;
        n_ready    = 0;
        exp_pc     = RESET_PC;
        exp_req_pc = RESET_PC;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'h0, bus.mem_req_o},    32'h0);
        chk({tag, "_valid"}, {31'h0, bus.inst_valid_o}, 32'h0);
        chk({tag, "_inst"},  bus.inst_o,                32'h0000_0013);
        chk({tag, "_iaddr"}, bus.inst_addr_o,           32'h0);
    endtask

    // One cycle against the memory model: inputs driven 1 after the edge, outputs sampled 4 after.
    task automatic run_cycle();
        int  n_dead, due;
        bit  exp_req, live_rv, exp_v, hs, cons, jmp;
        logic [31:0] ja;
        bus.mem_gnt_i    = ($urandom_range(0, 99) < p_gnt);
        bus.mem_rvalid_i = (q.size() > 0) && (q[0].due <= cyc);
        bus.mem_rdata_i  = bus.mem_rvalid_i ? word(q[0].addr) : $urandom;
        bus.hold_i       = ($urandom_range(0, 99) < p_hold);
        ja               = fj ? fj_addr : $urandom;
        jmp              = fj || ($urandom_range(0, 99) < p_jump);
        if (fj_co && bus.mem_req_o && bus.mem_gnt_i && bus.mem_rvalid_i) begin
            jmp     = 1'b1;
            fj_co   = 1'b0;
            co_done = 1'b1;
        end
        bus.jump_en_i   = jmp;
        bus.jump_addr_i = ja;
        #3;
        n_dead = 0;
        foreach (q[i]) if (q[i].ep != cur_ep) n_dead++;
        exp_req = (n_live + n_dead) < DEPTH;
        live_rv = bus.mem_rvalid_i && (q[0].ep == cur_ep);
        exp_v   = (n_ready > 0) || (BYP && live_rv);
        chk("req", {31'h0, bus.mem_req_o}, {31'h0, exp_req});
        if (exp_req) chk("mem_addr", bus.mem_addr_o, exp_req_pc);
        chk("valid", {31'h0, bus.inst_valid_o}, {31'h0, exp_v});
        if (exp_v) begin
            chk("inst_addr", bus.inst_addr_o, exp_pc);
            chk("inst", bus.inst_o, word(exp_pc));
        end else begin
            chk("idle_addr", bus.inst_addr_o, 32'h0);
            chk("idle_inst", bus.inst_o, 32'h0000_0013);
        end
        if (bus.inst_valid_o && !seen_valid) begin
            seen_valid = 1'b1;
            first_va   = bus.inst_addr_o;
        end
        hs = bus.mem_req_o && bus.mem_gnt_i;
        if (bus.mem_rvalid_i) begin
            if (live_rv && !jmp) n_ready++;
            void'(q.pop_front());
        end
        if (hs) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q.push_back('{bus.mem_addr_o, due, cur_ep});
            if (!jmp) begin
                n_live++;
                exp_req_pc += 32'd4;
            end
        end
        cons = exp_v && !bus.hold_i && !jmp;
        if (cons) begin
            if (wrap_phase && exp_pc == 32'h0) saw_wrap = 1'b1;
            n_live--;
            n_ready--;
            n_cons++;
            exp_pc += 32'd4;
        end
        if (jmp) begin
            cur_ep++;
            n_live     = 0;
            n_ready    = 0;
            exp_pc     = {ja[31:2], 2'b00};
            exp_req_pc = {ja[31:2], 2'b00};
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input int g, input int lmin, input int lmax, input int h, input int j);
        p_gnt = g; lat_min = lmin; lat_max = lmax; p_hold = h; p_jump = j;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   0, 0, 32'h0);
        tbl[1]  = mk(1, 1, 32'h0,   1, 0, 32'h0,   1, 32'h4,   0, 1, 32'h0);
        tbl[2]  = mk(1, 1, 32'h4,   1, 0, 32'h0,   0, 32'h8,   1, 1, 32'h0);
        tbl[3]  = mk(1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h8,   1, 1, 32'h0);
        tbl[4]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h8,   1, 1, 32'h0);
        tbl[5]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h8,   1, 1, 32'h4);
        tbl[6]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h8,   0, 0, 32'h0);
        tbl[7]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h8,   0, 0, 32'h0);
        tbl[8]  = mk(0, 1, 32'h8,   1, 0, 32'h0,   1, 32'hC,   0, 1, 32'h8);
        tbl[9]  = mk(0, 0, 32'h0,   0, 1, 32'h103, 1, 32'hC,   1, 1, 32'h8);
        tbl[10] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h100, 0, 0, 32'h0);
        tbl[11] = mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h100, 0, 0, 32'h0);
        tbl[12] = mk(0, 1, 32'h100, 0, 0, 32'h0,   1, 32'h104, 0, 1, 32'h100);
        tbl[13] = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h104, 1, 0, 32'h100);

        cyc = 0; n_cons = 0;
        fj = 0; fj_co = 0; co_done = 0; seen_valid = 0; wrap_phase = 0; saw_wrap = 0;
        fj_addr = 32'h0; first_va = 32'h0;
        set_mem(100, 1, 1, 0, 0);
        model_clear();
        drive_idle();
        #2;
        chk_reset_outputs("rst");

        // Vector table: words equal their address, hold during fill, jump to 0x103.
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            logic        ev;
            logic [31:0] eia;
            bus.mem_gnt_i    = tbl[i].gnt;
            bus.mem_rvalid_i = tbl[i].rv;
            bus.mem_rdata_i  = tbl[i].rdata;
            bus.hold_i       = tbl[i].hold;
            bus.jump_en_i    = tbl[i].jump;
            bus.jump_addr_i  = tbl[i].jaddr;
            ev  = BYP ? tbl[i].v_b : tbl[i].v_nb;
            eia = ev ? tbl[i].ia : 32'h0;
            #3;
            chk($sformatf("tbl%0d_req", i),   {31'h0, bus.mem_req_o},    {31'h0, tbl[i].req});
            chk($sformatf("tbl%0d_maddr", i), bus.mem_addr_o,            tbl[i].maddr);
            chk($sformatf("tbl%0d_valid", i), {31'h0, bus.inst_valid_o}, {31'h0, ev});
            chk($sformatf("tbl%0d_iaddr", i), bus.inst_addr_o,           eia);
            chk($sformatf("tbl%0d_inst", i),  bus.inst_o,                ev ? eia : 32'h0000_0013);
            @(posedge clk);
            #1;
        end

        // Jump to 0x103 with two grants outstanding: both responses dropped.
        do_reset();
        set_mem(100, 3, 3, 0, 0);
        repeat (2) run_cycle();
        fj = 1'b1; fj_addr = 32'h103;
        run_cycle();
        fj = 1'b0;
        chk("jump_target_addr", bus.mem_addr_o, 32'h100);
        seen_valid = 1'b0;
        for (int i = 0; i < 20 && !seen_valid; i++) run_cycle();
        chk("jump_first_valid_seen", {31'h0, seen_valid}, 32'h1);
        chk("jump_first_valid_addr", first_va, 32'h100);

        // Jump landing on a cycle with both a grant and a response.
        do_reset();
        set_mem(100, 1, 2, 30, 0);
        fj_co = 1'b1; co_done = 1'b0;
        for (int i = 0; i < 200 && fj_co; i++) run_cycle();
        fj_co = 1'b0;
        chk("coincide_jump_hit", {31'h0, co_done}, 32'h1);
        repeat (30) run_cycle();

        // Random memory latency 1..4 with grant gaps, holds and jumps.
        do_reset();
        n_cons = 0;
        set_mem(100, 1, 1, 0, 0);  repeat (300) run_cycle();
        set_mem(60, 1, 4, 20, 0);  repeat (800) run_cycle();
        set_mem(40, 1, 4, 40, 3);  repeat (800) run_cycle();
        set_mem(80, 2, 4, 10, 1);  repeat (800) run_cycle();
        chk("random_progress", {31'h0, n_cons > 500}, 32'h1);

        // PC wrap from 0xFFFF_FFFC to 0.
        set_mem(70, 1, 4, 10, 0);
        fj = 1'b1; fj_addr = 32'hFFFF_FFF0;
        run_cycle();
        fj = 1'b0;
        wrap_phase = 1'b1;
        repeat (60) run_cycle();
        wrap_phase = 1'b0;
        chk("pc_wrap_seen", {31'h0, saw_wrap}, 32'h1);

        // Reset mid-burst with queue full, then restart from RESET_PC.
        set_mem(100, 1, 1, 100, 0);
        repeat (10) run_cycle();
        chk("full_before_reset", {31'h0, bus.inst_valid_o}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        do_reset();
        set_mem(100, 1, 1, 0, 0);
        seen_valid = 1'b0;
        repeat (20) run_cycle();
        chk("restart_first_addr", first_va, RESET_PC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
